// File: rtl/w32_pkg.sv
// Shared types for the W32 primitive block: word type, ALU opcodes and
// the arbiter's state encoding.
package w32_pkg;

  typedef logic [31:0] w32_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_NOT = 2'd3
  } w32_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/w32_alu.sv
// Combinational 32-bit word ALU: ADD (carry dropped), AND, XOR, NOT.
module w32_alu
  import w32_pkg::*;
(
  input  w32_op_e op_i,
  input  w32_t    a_i,
  input  w32_t    b_i,
  output w32_t    result_o
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    result_o = '0;
    unique case (op_i)
      OP_ADD: result_o = a_i + b_i;
      OP_AND: result_o = a_i & b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_NOT: result_o = ~a_i;
    endcase
  end

endmodule

// File: rtl/w32_alu_arbiter.sv
// Round-robin arbiter sharing one w32_alu among NUM_REQ requesters, with a
// single registered result held until its owner accepts it.
module w32_alu_arbiter
  import w32_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [2*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [31:0]           resp_data,
  output logic [ID_W-1:0]       resp_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  arb_state_e       state_q, state_d;
  w32_t             resp_data_q, resp_data_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             can_accept, resp_done, grant;
  logic [ID_W-1:0]  winner;
  logic [ID_W:0]    pick;
  w32_op_e          op_sel;
  w32_t             a_sel, b_sel, alu_result;

  // Returns {found, index}; scanning from the far end down lets the nearest
  // requester after ptr overwrite the others.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] sel;
    int            idx;
    sel = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (valid[idx]) sel = {1'b1, ID_W'(idx)};
    end
    return sel;
  endfunction

  assign resp_done  = (state_q == ST_RESP) && resp_ready[resp_id_q];
  assign can_accept = (state_q == ST_IDLE) || resp_done;
  assign pick       = rr_pick(req_valid, rr_ptr_q);
  assign winner     = pick[ID_W-1:0];
  assign grant      = can_accept && pick[ID_W];

  always_comb begin
    op_sel = OP_ADD;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == winner) begin
        op_sel = w32_op_e'(req_op[2*i +: 2]);
        a_sel  = req_a[32*i +: 32];
        b_sel  = req_b[32*i +: 32];
      end
    end
  end

  w32_alu u_alu (
    .op_i     (op_sel),
    .a_i      (a_sel),
    .b_i      (b_sel),
    .result_o (alu_result)
  );

  always_comb begin
    state_d     = state_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    rr_ptr_d    = rr_ptr_q;
    op_count_d  = op_count_q;
    if (resp_done) begin
      op_count_d = op_count_q + CNT_W'(1);
      state_d    = ST_IDLE;
    end
    // A grant in the completing cycle reloads immediately, giving back-to-back results.
    if (grant) begin
      state_d     = ST_RESP;
      resp_data_d = alu_result;
      resp_id_d   = winner;
      rr_ptr_d    = winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      resp_data_q <= '0;
      resp_id_q   <= '0;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      op_count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      rr_ptr_q    <= rr_ptr_d;
      op_count_q  <= op_count_d;
    end
  end

  assign req_ready  = grant ? (NUM_REQ'(1) << winner) : '0;
  assign busy       = (state_q == ST_RESP);
  assign resp_valid = busy ? (NUM_REQ'(1) << resp_id_q) : '0;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_w32_alu_arbiter.sv
// Self-checking bench for w32_alu_arbiter: directed scenarios plus random
// traffic compared every cycle against a behavioural model.
module tb_w32_alu_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [2*N-1:0]  req_op;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     resp_data;
  logic [IW-1:0]   resp_id;
  logic            busy;
  logic [CW-1:0]   op_count;

  always #5 clk = ~clk;

  w32_alu_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy),
    .op_count   (op_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: one pending result slot, a last-granted index, a counter.
  bit          m_pend;
  int          m_owner;
  logic [31:0] m_data;
  int          m_rr;
  int          m_cnt;
  logic [N-1:0] m_acc;
  int          last_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    case (op)
      0: begin
        s = longint'(a) + longint'(b);
        return 32'(s % (longint'(1) << 32));
      end
      1: return a & b;
      2: return a ^ b;
      default: return 32'hFFFF_FFFF - a;
    endcase
  endfunction

  task automatic model_reset();
    m_pend  = 0;
    m_owner = 0;
    m_data  = '0;
    m_rr    = N - 1;
    m_cnt   = 0;
    m_acc   = '0;
  endtask

  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input int op, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]        = 1'b1;
    req_op[2*i +: 2]    = 2'(op);
    req_a[32*i +: 32]   = a;
    req_b[32*i +: 32]   = b;
  endtask

  // One clock: compare all outputs to the model, then advance the model at the edge.
  task automatic cycle();
    int           w;
    bit           can;
    logic [N-1:0] exp_rdy, exp_rv;
    #1;
    can     = !m_pend || resp_ready[m_owner];
    w       = model_pick();
    exp_rdy = (can && w >= 0) ? (N'(1) << w) : '0;
    exp_rv  = m_pend ? (N'(1) << m_owner) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("resp_valid", 32'(resp_valid), 32'(exp_rv));
    check("busy", 32'(busy), 32'(m_pend));
    check("op_count", 32'(op_count), 32'(m_cnt));
    if (m_pend) begin
      check("resp_data", resp_data, m_data);
      check("resp_id", 32'(resp_id), 32'(m_owner));
    end
    @(posedge clk);
    m_acc      = exp_rdy;
    last_grant = (exp_rdy != '0) ? w : -1;
    if (m_pend && resp_ready[m_owner]) begin
      m_cnt  = (m_cnt + 1) % (1 << CW);
      m_pend = 0;
    end
    if (exp_rdy != '0) begin
      m_pend  = 1;
      m_owner = w;
      m_data  = ref_alu(int'(req_op[2*w +: 2]), req_a[32*w +: 32], req_b[32*w +: 32]);
      m_rr    = w;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          order[$];
    logic [31:0] held;

    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
    rst_n      = 1'b0;
    model_reset();

    // Reset values
    @(negedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_id", 32'(resp_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_op_count", 32'(op_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD with carry out discarded, 1-cycle latency
    set_req(0, 0, 32'hFFFF_FFFF, 32'h0000_0002);
    resp_ready = '1;
    cycle();
    req_valid = '0;
    #1;
    check("add_resp_valid", 32'(resp_valid), 32'h1);
    check("add_resp_data", resp_data, 32'h0000_0001);
    check("add_resp_id", 32'(resp_id), 32'h0);
    cycle();
    #1;
    check("add_op_count", 32'(op_count), 32'h1);

    // NOT, AND, XOR from requester 2
    set_req(2, 3, 32'h0F0F_0000, 32'hDEAD_BEEF);
    cycle();
    #1;
    check("not_data", resp_data, 32'hF0F0_FFFF);
    check("not_valid", 32'(resp_valid), 32'h4);
    set_req(2, 1, 32'hF0F0_F0F0, 32'hFF00_FF00);
    cycle();
    #1;
    check("and_data", resp_data, 32'hF000_F000);
    set_req(2, 2, 32'hF0F0_F0F0, 32'hFF00_FF00);
    cycle();
    #1;
    check("xor_data", resp_data, 32'h0FF0_0FF0);
    req_valid = '0;
    cycle();

    // All requesters continuously valid: round-robin, no bubbles
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, i, 32'h1000_0000 * i, 32'h0000_0111 * (i + 1));
    resp_ready = '1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      order.push_back(last_grant);
    end
    req_valid = '0;
    cycle();
    for (int k = 0; k < 6; k++) check("rr_order", 32'(order[k]), 32'(k % N));
    #1;
    check("rr_op_count", 32'(op_count), 32'd6);

    // Owner stalls while another requester waits; non-owner ready bits ignored
    set_req(1, 0, 32'h1234_5678, 32'h1111_1111);
    resp_ready = '0;
    cycle();
    req_valid = '0;
    set_req(3, 2, 32'hAAAA_5555, 32'h0F0F_0F0F);
    resp_ready = 4'b1101;
    #1;
    held = resp_data;
    check("stall_data0", held, 32'h2345_6789);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_req_ready", 32'(req_ready), 32'h0);
      check("stall_busy", 32'(busy), 32'h1);
      check("stall_id", 32'(resp_id), 32'h1);
      check("stall_data", resp_data, held);
      cycle();
    end
    resp_ready = '1;
    #1;
    check("release_grant3", 32'(req_ready), 32'h8);
    cycle();
    req_valid = '0;
    #1;
    check("release_id", 32'(resp_id), 32'h3);
    check("release_data", resp_data, 32'hA5A5_5A5A);
    cycle();

    // Asynchronous reset while a result is pending
    set_req(0, 1, 32'hFFFF_0000, 32'h00FF_FF00);
    resp_ready = '0;
    cycle();
    req_valid = '0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_resp_valid", 32'(resp_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_data", resp_data, 32'h0);
    check("arst_id", 32'(resp_id), 32'h0);
    check("arst_op_count", 32'(op_count), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n      = 1'b1;
    resp_ready = '1;
    for (int k = 0; k < 3; k++) cycle();

    // Counter wrap at 2^CW
    do_reset();
    set_req(0, 0, 32'h5, 32'h7);
    resp_ready = '1;
    for (int k = 0; k < (1 << CW) - 1; k++) cycle();
    req_valid = '0;
    cycle();
    #1;
    check("cnt_max", 32'(op_count), 32'((1 << CW) - 1));
    set_req(0, 0, 32'h5, 32'h7);
    cycle();
    req_valid = '0;
    cycle();
    #1;
    check("cnt_wrap", 32'(op_count), 32'h0);

    // Random traffic; each requester holds its request until the model says it was accepted
    do_reset();
    m_acc = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, int'($urandom_range(0, 3)), $urandom, $urandom);
      end
      resp_ready = N'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
